// File: rtl/dlsc_axi_rstctrl_if.sv
// Command and response handshake bundle seen by the AXI reset sequencer.
// Latency: wires only, no storage.
// Backpressure: carries plain valid/ready pairs; the sequencer masks both sides of AR/AW.
interface dlsc_axi_rstctrl_if;
    logic in_ar_valid;
    logic in_ar_ready;
    logic out_ar_valid;
    logic out_ar_ready;
    logic in_aw_valid;
    logic in_aw_ready;
    logic out_aw_valid;
    logic out_aw_ready;
    logic r_valid;
    logic r_ready;
    logic r_last;
    logic b_valid;
    logic b_ready;

    // Sequencer side: gates commands and watches responses.
    modport slave (
        input  in_ar_valid, out_ar_ready, in_aw_valid, out_aw_ready,
        input  r_valid, r_ready, r_last, b_valid, b_ready,
        output in_ar_ready, out_ar_valid, in_aw_ready, out_aw_valid
    );

    // Environment side: upstream master, downstream slave and response observers.
    modport master (
        output in_ar_valid, out_ar_ready, in_aw_valid, out_aw_ready,
        output r_valid, r_ready, r_last, b_valid, b_ready,
        input  in_ar_ready, out_ar_valid, in_aw_ready, out_aw_valid
    );
endinterface

// File: rtl/dlsc_axi_rstctrl.sv
// Reset sequencer for an AXI slave segment: gates AR/AW, counts outstanding, drains, pulses s_rst, reopens.
// Latency: command gating is combinational from registered state; status outputs are registered.
// Backpressure: AR/AW valid and ready are both masked while blocked or with MOT transactions outstanding.
module dlsc_axi_rstctrl #(
    parameter int unsigned MOT        = 16,
    parameter int unsigned RST_CYCLES = 16,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rst_req,
    output logic                     rst_busy,
    output logic                     rst_done,
    output logic                     rst_timeout,
    output logic                     s_rst,
    dlsc_axi_rstctrl_if.slave        bus,
    output logic [$clog2(MOT+1)-1:0] rd_cnt,
    output logic [$clog2(MOT+1)-1:0] wr_cnt
);
    localparam int          CW   = $clog2(MOT + 1);
    localparam int unsigned TMAX = (TIMEOUT > RST_CYCLES) ? TIMEOUT : RST_CYCLES;
    localparam int          TW   = $clog2(TMAX + 1);

    localparam logic [CW-1:0] CNT_MAX  = CW'(MOT);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] RST_LAST = TW'(RST_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DRAIN, RESET, RECOVER} state_t;

    state_t        state;
    logic [TW-1:0] timer;   // drain timeout in DRAIN, pulse length in RESET
    logic          block;

    logic ar_open;
    logic aw_open;
    logic rd_inc;
    logic rd_dec;
    logic wr_inc;
    logic wr_dec;

    // Gating depends only on registered state, so ready never depends on valid.
    assign ar_open = !block && (rd_cnt != CNT_MAX);
    assign aw_open = !block && (wr_cnt != CNT_MAX);

    assign bus.out_ar_valid = bus.in_ar_valid && ar_open;
    assign bus.in_ar_ready  = bus.out_ar_ready && ar_open;
    assign bus.out_aw_valid = bus.in_aw_valid && aw_open;
    assign bus.in_aw_ready  = bus.out_aw_ready && aw_open;

    // A response with nothing outstanding is a stray and must not wrap the count.
    assign rd_inc = ar_open && bus.in_ar_valid && bus.out_ar_ready;
    assign rd_dec = bus.r_valid && bus.r_ready && bus.r_last && (rd_cnt != '0);
    assign wr_inc = aw_open && bus.in_aw_valid && bus.out_aw_ready;
    assign wr_dec = bus.b_valid && bus.b_ready && (wr_cnt != '0);

    assign rst_busy = block;

    // Outstanding counters; the slave forgets everything while it is held in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else if (state == RESET) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else begin
            rd_cnt <= rd_cnt + CW'(rd_inc) - CW'(rd_dec);
            wr_cnt <= wr_cnt + CW'(wr_inc) - CW'(wr_dec);
        end
    end

    // Sequencer: IDLE -> DRAIN -> RESET -> RECOVER -> IDLE; every system reset runs a full slave pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RESET;
            timer       <= '0;
            block       <= 1'b1;
            s_rst       <= 1'b1;
            rst_done    <= 1'b0;
            rst_timeout <= 1'b0;
        end else begin
            rst_done    <= 1'b0;
            rst_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (rst_req) begin
                        state <= DRAIN;
                        timer <= '0;
                        block <= 1'b1;
                    end
                end
                DRAIN: begin
                    // An empty bus wins over a coincident timeout.
                    if (rd_cnt == '0 && wr_cnt == '0) begin
                        state <= RESET;
                        timer <= '0;
                        s_rst <= 1'b1;
                    end else if (timer == TO_LAST) begin
                        state       <= RESET;
                        timer       <= '0;
                        s_rst       <= 1'b1;
                        rst_timeout <= 1'b1;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                RESET: begin
                    if (timer == RST_LAST) begin
                        state <= RECOVER;
                        timer <= '0;
                        s_rst <= 1'b0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                RECOVER: begin
                    state    <= IDLE;
                    block    <= 1'b0;
                    rst_done <= 1'b1;
                end
                default: begin
                    state <= RESET;
                    timer <= '0;
                    block <= 1'b1;
                    s_rst <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dlsc_axi_rstctrl.sv
// Scoreboard bench for dlsc_axi_rstctrl: stimulus pushes expectations, negedge monitors pop and compare.
// Latency: expectations are stamped with the absolute cycle at which they must hold.
// Backpressure: downstream ready held high except where a case drops it.
module tb_dlsc_axi_rstctrl;
    localparam int S_RDCNT = 0;
    localparam int S_WRCNT = 1;
    localparam int S_ARRDY = 2;
    localparam int S_ARVLD = 3;
    localparam int S_AWRDY = 4;
    localparam int S_AWVLD = 5;
    localparam int S_SRST  = 6;
    localparam int S_BUSY  = 7;

    typedef struct {
        int    cyc;
        int    sig;
        int    val;
        string name;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       rst_req;
    logic       rst_busy;
    logic       rst_done;
    logic       rst_timeout;
    logic       s_rst;
    logic [4:0] rd_cnt;
    logic [4:0] wr_cnt;

    dlsc_axi_rstctrl_if bus ();

    dlsc_axi_rstctrl #(.MOT(16), .RST_CYCLES(16), .TIMEOUT(1024)) dut (
        .clk         (clk),
        .rst         (rst),
        .rst_req     (rst_req),
        .rst_busy    (rst_busy),
        .rst_done    (rst_done),
        .rst_timeout (rst_timeout),
        .s_rst       (s_rst),
        .bus         (bus.slave),
        .rd_cnt      (rd_cnt),
        .wr_cnt      (wr_cnt)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   slen   = 0;
    exp_t exp_q[$];
    exp_t keep_q[$];
    int   done_q[$];
    int   to_q[$];
    int   len_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic int sig_val(int id);
        case (id)
            S_RDCNT: return int'(rd_cnt);
            S_WRCNT: return int'(wr_cnt);
            S_ARRDY: return int'(bus.in_ar_ready);
            S_ARVLD: return int'(bus.out_ar_valid);
            S_AWRDY: return int'(bus.in_aw_ready);
            S_AWVLD: return int'(bus.out_aw_valid);
            S_SRST:  return int'(s_rst);
            default: return int'(rst_busy);
        endcase
    endfunction

    task automatic expect_at(int d, int sig, int val, string name);
        exp_t e;
        e.cyc  = cyc + d;
        e.sig  = sig;
        e.val  = val;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drop rst; when the sequence is allowed to complete, schedule its full pulse and return to IDLE.
    task automatic release_rst(bit full);
        rst = 1'b0;
        if (full) begin
            done_q.push_back(cyc + 17);
            len_q.push_back(16);
            expect_at(15, S_SRST,  1, "srst_last_cycle");
            expect_at(16, S_SRST,  0, "recover_srst");
            expect_at(16, S_BUSY,  1, "recover_busy");
            expect_at(16, S_ARRDY, 0, "recover_blocked");
            expect_at(17, S_BUSY,  0, "idle_busy");
            expect_at(17, S_ARRDY, 1, "idle_ar_open");
        end
    endtask

    // Monitor: stamped expectations, pulse events and s_rst pulse lengths.
    always @(negedge clk) begin
        keep_q.delete();
        foreach (exp_q[i]) begin
            if (exp_q[i].cyc == cyc) chk(exp_q[i].name, sig_val(exp_q[i].sig), exp_q[i].val);
            else keep_q.push_back(exp_q[i]);
        end
        exp_q = keep_q;

        if (rst_done) begin
            if (done_q.size() == 0) chk("rst_done_unexpected", cyc, -1);
            else chk("rst_done_cycle", cyc, done_q.pop_front());
        end
        if (rst_timeout) begin
            if (to_q.size() == 0) chk("rst_timeout_unexpected", cyc, -1);
            else chk("rst_timeout_cycle", cyc, to_q.pop_front());
        end

        if (rst) begin
            slen = 0;
        end else if (s_rst) begin
            slen++;
        end else if (slen != 0) begin
            if (len_q.size() == 0) chk("s_rst_unexpected", slen, -1);
            else chk("s_rst_length", slen, len_q.pop_front());
            slen = 0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        rst              = 1'b1;
        rst_req          = 1'b0;
        bus.in_ar_valid  = 1'b0;
        bus.out_ar_ready = 1'b1;
        bus.in_aw_valid  = 1'b0;
        bus.out_aw_ready = 1'b1;
        bus.r_valid      = 1'b0;
        bus.r_ready      = 1'b1;
        bus.r_last       = 1'b0;
        bus.b_valid      = 1'b0;
        bus.b_ready      = 1'b1;

        // Reset values
        repeat (3) tick();
        expect_at(0, S_SRST,  1, "reset_srst");
        expect_at(0, S_BUSY,  1, "reset_busy");
        expect_at(0, S_RDCNT, 0, "reset_rd_cnt");
        expect_at(0, S_WRCNT, 0, "reset_wr_cnt");
        expect_at(0, S_ARRDY, 0, "reset_ar_blocked");
        tick();
        release_rst(1'b1);
        repeat (18) tick();

        // in_ar_ready follows out_ar_ready when open
        bus.out_ar_ready = 1'b0;
        expect_at(0, S_ARRDY, 0, "ar_ready_follows");
        tick();
        bus.out_ar_ready = 1'b1;

        // Fill reads to MOT, then one completion reopens AR
        bus.in_ar_valid = 1'b1;
        expect_at(0, S_ARVLD, 1, "ar_pass");
        repeat (16) tick();
        expect_at(0, S_RDCNT, 16, "rd_full");
        expect_at(0, S_ARRDY, 0, "rd_full_ready");
        expect_at(0, S_ARVLD, 0, "rd_full_valid");
        bus.r_valid = 1'b1;
        bus.r_last  = 1'b1;
        tick();
        bus.r_valid = 1'b0;
        expect_at(0, S_RDCNT, 15, "rd_after_rlast");
        expect_at(0, S_ARRDY, 1, "ar_reopen_ready");
        expect_at(0, S_ARVLD, 1, "ar_reopen_valid");
        tick();
        bus.in_ar_valid = 1'b0;
        expect_at(0, S_RDCNT, 16, "rd_refill");
        bus.r_valid = 1'b1;
        repeat (11) tick();
        bus.r_valid = 1'b0;

        // Simultaneous accept and completion at rd_cnt=5
        expect_at(0, S_RDCNT, 5, "rd_five");
        bus.in_ar_valid = 1'b1;
        bus.r_valid     = 1'b1;
        expect_at(1, S_RDCNT, 5, "rd_inc_dec");
        tick();
        bus.in_ar_valid = 1'b0;
        bus.r_last      = 1'b0;
        expect_at(1, S_RDCNT, 5, "r_non_last");
        tick();
        bus.r_last = 1'b1;
        expect_at(5, S_RDCNT, 0, "rd_empty");
        expect_at(6, S_RDCNT, 0, "rd_stray_ignored");
        repeat (6) tick();
        bus.r_valid = 1'b0;
        bus.r_last  = 1'b0;

        // Drain of three writes
        bus.in_aw_valid = 1'b1;
        repeat (3) tick();
        bus.in_aw_valid = 1'b0;
        expect_at(0, S_WRCNT, 3, "wr_three");
        rst_req = 1'b1;
        tick();
        rst_req         = 1'b0;
        bus.in_aw_valid = 1'b1;
        expect_at(0, S_BUSY,  1, "drain_busy");
        expect_at(0, S_AWRDY, 0, "drain_aw_ready");
        expect_at(0, S_AWVLD, 0, "drain_aw_valid");
        for (int k = 0; k < 3; k++) begin
            repeat (k == 0 ? 1 : 3) tick();
            bus.b_valid = 1'b1;
            tick();
            bus.b_valid = 1'b0;
            expect_at(0, S_WRCNT, 2 - k, "wr_drain");
        end
        expect_at(0, S_SRST, 0, "drain_holds");
        expect_at(0, S_AWVLD, 0, "drain_no_aw");
        expect_at(1, S_SRST, 1, "reset_after_empty");
        expect_at(18, S_BUSY, 0, "drain_done_idle");
        expect_at(18, S_WRCNT, 0, "wr_after_seq");
        done_q.push_back(cyc + 18);
        len_q.push_back(16);
        tick();
        bus.in_aw_valid = 1'b0;
        repeat (17) tick();

        // Drain timeout with one read never completed
        bus.in_ar_valid = 1'b1;
        tick();
        bus.in_ar_valid = 1'b0;
        expect_at(0, S_RDCNT, 1, "rd_one");
        rst_req = 1'b1;
        tick();
        rst_req = 1'b0;
        c = cyc;
        expect_at(1023, S_RDCNT, 1, "timeout_rd_held");
        expect_at(1023, S_SRST, 0, "timeout_not_yet");
        expect_at(1024, S_SRST, 1, "timeout_reset");
        expect_at(1025, S_RDCNT, 0, "timeout_rd_cleared");
        to_q.push_back(c + 1024);
        done_q.push_back(c + 1041);
        len_q.push_back(16);
        repeat (1041) tick();

        // System reset mid-DRAIN, then mid-RESET
        bus.in_ar_valid = 1'b1;
        tick();
        bus.in_ar_valid = 1'b0;
        rst_req = 1'b1;
        tick();
        rst_req = 1'b0;
        repeat (8) tick();
        rst = 1'b1;
        expect_at(0, S_SRST,  1, "abort_drain_srst");
        expect_at(0, S_RDCNT, 0, "abort_drain_rd_cnt");
        expect_at(0, S_BUSY,  1, "abort_drain_busy");
        expect_at(0, S_ARRDY, 0, "abort_drain_blocked");
        repeat (2) tick();
        release_rst(1'b0);
        repeat (5) tick();
        rst = 1'b1;
        expect_at(0, S_SRST, 1, "abort_reset_srst");
        expect_at(0, S_BUSY, 1, "abort_reset_busy");
        tick();
        release_rst(1'b1);
        repeat (18) tick();

        // Held rst_req on an empty bus: two back-to-back sequences
        c = cyc;
        rst_req = 1'b1;
        expect_at(1, S_BUSY, 1, "empty_drain_busy");
        expect_at(1, S_SRST, 0, "empty_drain_srst");
        expect_at(2, S_SRST, 1, "empty_reset_entry");
        expect_at(19, S_BUSY, 0, "held_req_idle");
        expect_at(20, S_BUSY, 1, "held_req_restart");
        done_q.push_back(c + 19);
        done_q.push_back(c + 38);
        len_q.push_back(16);
        len_q.push_back(16);
        repeat (20) tick();
        rst_req = 1'b0;
        repeat (22) tick();

        chk("pending_expectations", exp_q.size(), 0);
        chk("pending_rst_done", done_q.size(), 0);
        chk("pending_rst_timeout", to_q.size(), 0);
        chk("pending_s_rst_pulses", len_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
